// File: rtl/hdmi_vram_scanout.sv
// Raster timing generator and pixel streamer reading the frame buffer through VRAM port B.
// Define HDMI_VRAM_SCANOUT_RGB332_EN to decode bytes as RGB332; otherwise bytes are grayscale.
module hdmi_vram_scanout #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] frame_base,
  output logic        enb,
  output logic [19:0] addrb,
  input  logic [7:0]  doutb,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [19:0]   row_base;

  logic h_act, v_act, act, h_end, v_end;
  logic h_sync_rgn, v_sync_rgn, first_px;

  logic s1_act, s1_hs, s1_vs, s1_first;

  function automatic logic [23:0] decode(input logic [7:0] p);
`ifdef HDMI_VRAM_SCANOUT_RGB332_EN
    return {p[7:5], p[7:5], p[7:6],
            p[4:2], p[4:2], p[4:3],
            p[1:0], p[1:0], p[1:0], p[1:0]};
`else
    return {p, p, p};
`endif
  endfunction

  // Stage 0 decode of the raster position.
  always_comb begin
    h_end      = (int'(h_cnt) == H_TOTAL - 1);
    v_end      = (int'(v_cnt) == V_TOTAL - 1);
    h_act      = (int'(h_cnt) < H_ACTIVE);
    v_act      = (int'(v_cnt) < V_ACTIVE);
    act        = h_act && v_act;
    h_sync_rgn = (int'(h_cnt) >= H_ACTIVE + H_FP) &&
                 (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
    v_sync_rgn = (int'(v_cnt) >= V_ACTIVE + V_FP) &&
                 (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);
    first_px   = (h_cnt == '0) && (v_cnt == '0);
    enb        = act;
    addrb      = act ? (row_base + 20'(h_cnt)) : 20'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_end) begin
      h_cnt <= '0;
      v_cnt <= v_end ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Row start address advances by one line per active line; frame_base is
  // picked up only at the very last clock of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base <= 20'h0;
    end else if (h_end) begin
      if (v_end)
        row_base <= frame_base;
      else if (v_act)
        row_base <= row_base + 20'(H_ACTIVE);
    end
  end

  // Stage 1: flags aligned with doutb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_act   <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_first <= 1'b0;
    end else begin
      s1_act   <= act;
      s1_hs    <= h_sync_rgn;
      s1_vs    <= v_sync_rgn;
      s1_first <= first_px;
    end
  end

  // Stage 2: output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de          <= 1'b0;
      rgb         <= 24'h0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      de          <= s1_act;
      rgb         <= s1_act ? decode(doutb) : 24'h0;
      hsync       <= s1_hs ? HS_POL : ~HS_POL;
      vsync       <= s1_vs ? VS_POL : ~VS_POL;
      frame_start <= s1_first;
    end
  end

endmodule

// File: doc/hdmi_vram_scanout.md
# hdmi_vram_scanout

Display-side reader of the dual-port HDMI frame buffer: generates video raster timing and streams pixels out of the VRAM's read-only port B. It sits between the VRAM (port B: `enb`/`addrb`/`doutb`, 1-cycle read latency) and the HDMI/TMDS encoder. It outputs time-aligned `hsync`, `vsync`, `de` and 24-bit RGB. The CPU side writes the frame buffer through port A independently.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `HS_POL`, 0, hsync active level (0 = active-low)
- `VS_POL`, 0, vsync active level
- `clk`  in  1  pixel clock; also VRAM `clkb`
- `rst`  in  1  reset, asynchronous, active-high
- `frame_base`  in  20  VRAM byte address of pixel (0,0); sampled once per frame
- `enb`  out  1  VRAM port B enable
- `addrb`  out  20  VRAM port B address
- `doutb`  in  8  VRAM port B read data, valid 1 clk after `enb`
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `de`  out  1  data enable (active pixel)
- `rgb`  out  24  pixel {R[7:0],G[7:0],B[7:0]}; 0 when `de`=0
- `frame_start`  out  1  one-clk pulse, aligned with first active pixel of a frame

## Operation
- Stage 0: counters `h_cnt` 0..H_TOTAL-1 and `v_cnt` 0..V_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise). `h_cnt` wraps to 0 and `v_cnt` increments at H_TOTAL-1. `v_cnt` wraps at V_TOTAL-1 on the same clk as `h_cnt` wrap.
- Horizontal regions by `h_cnt`: ACTIVE [0,H_ACTIVE), FP, SYNC, BP in order; vertical regions by `v_cnt` likewise.
- Active = both counters in ACTIVE. `enb` = active, combinational from stage-0 counters.
- Address generation without multiplier: `row_base` register; `addrb` = `row_base` + `h_cnt` (20-bit, wraps mod 2^20).
- `row_base` += H_ACTIVE at `h_cnt`=H_TOTAL-1 when `v_cnt` is an active line.
- `row_base` loads `frame_base` at `h_cnt`=H_TOTAL-1, `v_cnt`=V_TOTAL-1; this is the only sampling point, so mid-frame changes take effect next frame.
- `addrb` is don't-care while `enb`=0 (drive 0).
- Stage 1: `de`/sync/first-pixel flags delayed one register; `doutb` valid here.
- Stage 2: output registers. `rgb` = decode(`doutb`) when stage-1 active, else 0.
- Sync level: `hsync` = HS_POL when in H SYNC region, else ~HS_POL; `vsync` likewise per V SYNC lines (asserted for whole lines, changes at `h_cnt`=0).
- `frame_start` = stage-2 image of (`h_cnt`=0 && `v_cnt`=0).

## Timing
- Reset values: `h_cnt`=0, `v_cnt`=0, `row_base`=0, `de`=0, `rgb`=0, `frame_start`=0, `hsync`=~HS_POL, `vsync`=~VS_POL, pipeline flags cleared.
- `enb`/`addrb` follow counters combinationally; `enb`=1 in the first clk after reset release (counters at 0,0).
- First frame after reset reads from `row_base`=0, not `frame_base`.
- Fixed latency: every output is exactly 2 clks behind the stage-0 counter state producing it. `de`, syncs and `rgb` are mutually aligned.
- Reset mid-frame: all outputs return to reset values asynchronously; raster restarts at (0,0) on release.
- No back-pressure; VRAM port B is never stalled. Port-A writes to the address being read return pre-write data per VRAM rule; no coherence is provided.

## Configuration
- `HDMI_VRAM_SCANOUT_RGB332_EN` defined: byte is RGB332. R = {p[7:5],p[7:5],p[7:6]}, G = {p[4:2],p[4:2],p[4:3]}, B = {p[1:0],p[1:0],p[1:0],p[1:0]}.
- Not defined: byte is grayscale. R=G=B=p.

## Test plan
- Small raster H_ACTIVE=4,H_FP=1,H_SYNC=2,H_BP=1,V_ACTIVE=3,V_FP=1,V_SYNC=1,V_BP=1 -> `de` high 4 of every 8 clks on 3 of 6 lines. `hsync` low 2 clks starting 5 clks after `de` rise. Frame period 48 clks.
- Same raster, `frame_base`=0x00100, VRAM model filled addr[7:0] -> second frame `addrb` sequence 0x100..0x10B. `rgb` matches decode of each byte 2 clks after issue.
- `frame_base`=0xFFFFE -> addresses 0xFFFFE,0xFFFFF,0x00000,... (wrap). `frame_base` changed mid-frame -> no effect until next frame.
- RGB332 build, byte 0xE0 -> `rgb`=0xFF0000; 0x1C -> 0x00FF00; 0x03 -> 0x0000FF. Grayscale build, 0x5A -> 0x5A5A5A.
- `rst` asserted mid-active-line -> `de`=0, `rgb`=0, syncs inactive immediately. After release, `frame_start` pulses 2 clks later with pixel from address 0.
- Default 640x480 params, HS_POL=VS_POL=1 -> 800x525 clks/frame; `frame_start` period 420000 clks; sync polarity inverted.
